// File: rtl/ladybird_inst_injector_if.sv
// ladybird_inst_injector_if
//   Bundles the command port (debug/boot controller side), the instruction
//   issue port (core fetch side) and the status outputs of the injector.
//   master : the injector itself (accepts commands, offers instructions)
//   slave  : the surrounding controller/core (issues commands, accepts
//            instructions, reports retirement)
//   Signals:
//     cmd_valid/cmd_ready      command handshake
//     cmd_op[1:0]              0 EXEC, 1 WRITE_REG, 2 READ_REG, 3 illegal
//     cmd_reg[4:0]             target/source register index
//     cmd_data[31:0]           raw instruction (EXEC) or value (WRITE_REG)
//     inst_valid/inst_ready    instruction handshake
//     inst[31:0]               instruction word, NOP when not valid
//     inst_retire              one-cycle pulse per retired injected word
//     busy, done, error        status; error is qualified by done
interface ladybird_inst_injector_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_reg;
    logic [31:0] cmd_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        inst_retire;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        input  cmd_valid, cmd_op, cmd_reg, cmd_data, inst_ready, inst_retire,
        output cmd_ready, inst_valid, inst, busy, done, error
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_reg, cmd_data, inst_ready, inst_retire,
        input  cmd_ready, inst_valid, inst, busy, done, error
    );
endinterface

// File: rtl/ladybird_inst_injector.sv
// ladybird_inst_injector
//   Debug/boot instruction sequencer placed in front of the core fetch path.
//   Accepts one command at a time, expands it into one or two RV32I words,
//   offers them to the core over a valid/ready port and completes once all
//   issued words have retired, or aborts with an error when the retire
//   timeout expires.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_IDLE     | ready for a command; illegal ops complete here directly
//   ST_ISSUE    | offering buffered words to the core, one per handshake
//   ST_WAIT     | all words issued; waiting for outstanding retires/timeout
//
//   Ports:
//     clk    clock, all state on the rising edge
//     nrst   asynchronous active-low reset
//     bus    ladybird_inst_injector_if.master (command, issue and status)
//   Parameters:
//     SCRATCH_OFS  signed 12-bit offset from x0 used by the READ_REG store
//     TIMEOUT      cycles allowed in ST_WAIT before aborting (>= 2)
module ladybird_inst_injector #(
    parameter logic [11:0] SCRATCH_OFS = 12'h7F0,
    parameter int          TIMEOUT     = 1024
) (
    input  logic                    clk,
    input  logic                    nrst,
    ladybird_inst_injector_if.master bus
);
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [1:0]  OP_EXEC    = 2'd0;
    localparam logic [1:0]  OP_WRITE   = 2'd1;
    localparam logic [1:0]  OP_READ    = 2'd2;
    localparam logic [1:0]  OP_ILLEGAL = 2'd3;
    localparam int          TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           done_q, done_d;
    logic           error_q, error_d;

    logic [31:0]    word0_q, word1_q;
    logic           two_q;
    logic           idx_q;
    logic [1:0]     outst_q;
    logic [TW-1:0]  tmr_q;

    logic           accept;
    logic           legal;
    logic           hs;
    logic           last_word;
    logic           retire_eff;
    logic           timeout_hit;

    logic [11:0]    lo;
    logic [19:0]    hi;
    logic [31:0]    exp_w0, exp_w1;
    logic           exp_two;

    assign accept      = bus.cmd_valid && (state_q == ST_IDLE);
    assign legal       = (bus.cmd_op != OP_ILLEGAL);
    assign hs          = (state_q == ST_ISSUE) && bus.inst_ready;
    assign last_word   = !two_q || idx_q;
    assign retire_eff  = bus.inst_retire && (outst_q != 2'd0);
    // Timer counts down from TIMEOUT-1 on entry; terminal count is the last
    // allowed cycle, so done lands exactly TIMEOUT cycles after entry.
    assign timeout_hit = (state_q == ST_WAIT) && (outst_q != 2'd0) && (tmr_q == '0);

    assign bus.cmd_ready  = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.inst_valid = (state_q == ST_ISSUE);
    assign bus.inst       = (state_q == ST_ISSUE) ? (idx_q ? word1_q : word0_q) : NOP;
    assign bus.done       = done_q;
    assign bus.error      = error_q;

    // Command expansion. The +data[11] on the upper part compensates for the
    // sign extension ADDI applies to its 12-bit immediate.
    always_comb begin
        lo      = bus.cmd_data[11:0];
        hi      = bus.cmd_data[31:12] + {19'd0, bus.cmd_data[11]};
        exp_w0  = NOP;
        exp_w1  = NOP;
        exp_two = 1'b0;
        case (bus.cmd_op)
            OP_EXEC: exp_w0 = bus.cmd_data;
            OP_WRITE: begin
                if (bus.cmd_reg == 5'd0) begin
                    exp_w0 = NOP;
                end else if (hi == 20'd0) begin
                    exp_w0 = {lo, 5'd0, 3'b000, bus.cmd_reg, OPC_OPIMM};
                end else begin
                    exp_two = 1'b1;
                    exp_w0  = {hi, bus.cmd_reg, OPC_LUI};
                    exp_w1  = {lo, bus.cmd_reg, 3'b000, bus.cmd_reg, OPC_OPIMM};
                end
            end
            OP_READ: exp_w0 = {SCRATCH_OFS[11:5], bus.cmd_reg, 5'd0, 3'b010,
                               SCRATCH_OFS[4:0], OPC_STORE};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_d = ST_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (hs && last_word) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (outst_q == 2'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word0_q <= NOP;
            word1_q <= NOP;
            two_q   <= 1'b0;
            idx_q   <= 1'b0;
            outst_q <= 2'd0;
            tmr_q   <= '0;
        end else begin
            if (accept && legal) begin
                word0_q <= exp_w0;
                word1_q <= exp_w1;
                two_q   <= exp_two;
                idx_q   <= 1'b0;
            end else if (hs && !last_word) begin
                idx_q <= 1'b1;
            end

            if (hs && last_word) begin
                tmr_q <= TMR_LOAD;
            end else if ((state_q == ST_WAIT) && (tmr_q != '0)) begin
                tmr_q <= tmr_q - 1'b1;
            end

            // A retire while nothing is outstanding is dropped; a handshake
            // and a counted retire in the same cycle cancel out.
            if (timeout_hit) begin
                outst_q <= 2'd0;
            end else if (hs && !retire_eff) begin
                outst_q <= outst_q + 2'd1;
            end else if (!hs && retire_eff) begin
                outst_q <= outst_q - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_ladybird_inst_injector.sv
// tb_ladybird_inst_injector
//   Self-checking bench for ladybird_inst_injector (TIMEOUT=8,
//   SCRATCH_OFS=12'h7F0). A transaction-level model predicts every output
//   each cycle; directed sequences additionally pin issued words, done/error
//   and timing to hand-computed literals.
module tb_ladybird_inst_injector;
    localparam int          TMO = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic nrst;

    ladybird_inst_injector_if bus();

    ladybird_inst_injector #(
        .SCRATCH_OFS(12'h7F0),
        .TIMEOUT    (TMO)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase = 0;      // 0 idle, 1 issuing, 2 awaiting retires
    bit [31:0]   m_words[$];
    int          m_outst = 0;
    int          m_wait  = 0;
    bit          m_done  = 1'b0;
    bit          m_err   = 1'b0;
    bit          model_live = 1'b0;
    bit          mh_hs, mh_ret, mh_nd, mh_ne, mh_tout;

    function automatic bit [31:0] enc_addi(bit [31:0] rd, bit [31:0] rs, bit [31:0] imm);
        return (imm << 20) | (rs << 15) | (rd << 7) | 32'h13;
    endfunction

    function automatic bit [31:0] enc_lui(bit [31:0] rd, bit [31:0] imm20);
        return (imm20 << 12) | (rd << 7) | 32'h37;
    endfunction

    function automatic bit [31:0] enc_sw(bit [31:0] rs2, bit [31:0] rs1, bit [31:0] imm);
        return ((imm >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
               | ((imm & 32'd31) << 7) | 32'h23;
    endfunction

    function automatic void model_expand(bit [1:0] op, bit [4:0] r, bit [31:0] d);
        bit [31:0] rr, lo, hi;
        rr = {27'd0, r};
        lo = d & 32'hFFF;
        hi = ((d >> 12) + ((d >> 11) & 32'd1)) & 32'hF_FFFF;
        m_words.delete();
        if (op == 2'd0) begin
            m_words.push_back(d);
        end else if (op == 2'd1) begin
            if (rr == 0) m_words.push_back(NOP);
            else if (hi == 0) m_words.push_back(enc_addi(rr, 0, lo));
            else begin
                m_words.push_back(enc_lui(rr, hi));
                m_words.push_back(enc_addi(rr, rr, lo));
            end
        end else begin
            m_words.push_back(enc_sw(rr, 0, 32'h7F0));
        end
    endfunction

    always @(posedge clk) begin
        if (!nrst) begin
            m_phase = 0; m_words.delete(); m_outst = 0; m_wait = 0;
            m_done = 1'b0; m_err = 1'b0; model_live = 1'b1;
        end else if (model_live) begin
            mh_hs   = (m_phase == 1) && bus.inst_ready;
            mh_ret  = bus.inst_retire && (m_outst > 0);
            mh_nd   = 1'b0; mh_ne = 1'b0; mh_tout = 1'b0;
            case (m_phase)
                0: if (bus.cmd_valid) begin
                       if (bus.cmd_op == 2'd3) begin mh_nd = 1'b1; mh_ne = 1'b1; end
                       else begin model_expand(bus.cmd_op, bus.cmd_reg, bus.cmd_data); m_phase = 1; end
                   end
                1: if (mh_hs) begin
                       void'(m_words.pop_front());
                       if (m_words.size() == 0) begin m_phase = 2; m_wait = 0; end
                   end
                default: begin
                    if (m_outst == 0) begin m_phase = 0; mh_nd = 1'b1; end
                    else if (m_wait == TMO - 1) begin
                        m_phase = 0; mh_nd = 1'b1; mh_ne = 1'b1; mh_tout = 1'b1;
                    end else m_wait++;
                end
            endcase
            if (mh_tout) m_outst = 0;
            else m_outst = m_outst + (mh_hs ? 1 : 0) - (mh_ret ? 1 : 0);
            m_done = mh_nd;
            m_err  = mh_ne;
        end
    end

    // ---------------- compare / monitor ----------------
    int          neg_cnt = 0;
    int          done_cnt = 0;
    int          valid_cnt = 0;
    int          last_hs_neg = 0;
    int          done_neg = 0;
    logic        last_err = 1'b0;
    logic [31:0] hs_log[$];

    always @(negedge clk) begin
        neg_cnt++;
        if (!nrst) begin
            chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
            chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
            chk("rst_busy", {31'd0, bus.busy}, 32'd0);
            chk("rst_done", {31'd0, bus.done}, 32'd0);
            chk("rst_inst", bus.inst, NOP);
        end else if (model_live) begin
            chk("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, m_phase == 0});
            chk("busy", {31'd0, bus.busy}, {31'd0, m_phase != 0});
            chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, m_phase == 1});
            chk("inst", bus.inst, (m_phase == 1) ? m_words[0] : NOP);
            chk("done", {31'd0, bus.done}, {31'd0, m_done});
            if (bus.done) chk("error", {31'd0, bus.error}, {31'd0, m_err});
            if (bus.inst_valid) valid_cnt++;
            if (bus.inst_valid && bus.inst_ready) begin
                hs_log.push_back(bus.inst);
                last_hs_neg = neg_cnt;
            end
            if (bus.done) begin
                done_cnt++;
                last_err = bus.error;
                done_neg = neg_cnt;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [4:0] r, input logic [31:0] d);
        int b;
        b = 50;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_reg = r; bus.cmd_data = d;
        while (!bus.cmd_ready && b > 0) begin cyc(1); b--; end
        chk("cmd_accept", {31'd0, bus.cmd_ready}, 32'd1);
        cyc(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_hs(input string nm, input int target);
        int b;
        b = 50;
        while (hs_log.size() < target && b > 0) begin cyc(1); b--; end
        chk(nm, hs_log.size(), target);
    endtask

    task automatic wait_done(input string nm, input int start);
        int b;
        b = 50;
        while (done_cnt == start && b > 0) begin cyc(1); b--; end
        chk(nm, done_cnt, start + 1);
    endtask

    task automatic pulse_retire();
        bus.inst_retire = 1'b1;
        cyc(1);
        bus.inst_retire = 1'b0;
    endtask

    task automatic check_words(input string nm, input int base, input int n,
                               input logic [31:0] w0, input logic [31:0] w1);
        chk({nm, "_count"}, hs_log.size() - base, n);
        if (hs_log.size() > base) chk({nm, "_w0"}, hs_log[base], w0);
        if (n == 2 && hs_log.size() > base + 1) chk({nm, "_w1"}, hs_log[base + 1], w1);
    endtask

    task automatic run_simple(input string nm, input logic [1:0] op, input logic [4:0] r,
                              input logic [31:0] d, input int n,
                              input logic [31:0] w0, input logic [31:0] w1);
        int base, d0;
        base = hs_log.size();
        d0   = done_cnt;
        bus.inst_ready = 1'b1;
        send_cmd(op, r, d);
        wait_hs({nm, "_hs"}, base + n);
        repeat (n) pulse_retire();
        wait_done({nm, "_done"}, d0);
        check_words(nm, base, n, w0, w1);
        chk({nm, "_err"}, {31'd0, last_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0, v0;
        nrst = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_reg = 5'd0; bus.cmd_data = 32'd0;
        bus.inst_ready = 1'b1; bus.inst_retire = 1'b0;
        cyc(3);
        chk("init_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        chk("init_busy", {31'd0, bus.busy}, 32'd0);
        chk("init_inst", bus.inst, NOP);
        chk("init_error", {31'd0, bus.error}, 32'd0);
        nrst = 1'b1;
        cyc(2);

        run_simple("wr_x5", 2'd1, 5'd5, 32'h1234_5FFF, 2, 32'h1234_62B7, 32'hFFF2_8293);
        run_simple("wr_x1", 2'd1, 5'd1, 32'h0000_0123, 1, 32'h1230_0093, NOP);
        run_simple("wr_x0", 2'd1, 5'd0, 32'hDEAD_BEEF, 1, NOP, NOP);
        run_simple("wr_wrap", 2'd1, 5'd3, 32'hFFFF_F800, 1, 32'h8000_0193, NOP);

        // READ_REG with the core stalling fetch for 5 cycles
        base = hs_log.size(); d0 = done_cnt;
        bus.inst_ready = 1'b0;
        send_cmd(2'd2, 5'd7, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            chk("rd_stall_valid", {31'd0, bus.inst_valid}, 32'd1);
            chk("rd_stall_inst", bus.inst, 32'h7E70_2823);
            cyc(1);
        end
        chk("rd_stall_nohs", hs_log.size(), base);
        bus.inst_ready = 1'b1;
        wait_hs("rd_hs", base + 1);
        pulse_retire();
        wait_done("rd_done", d0);
        check_words("rd_x7", base, 1, 32'h7E70_2823, NOP);

        // stray retire in idle must be ignored; then EXEC
        pulse_retire();
        run_simple("exec", 2'd0, 5'd0, 32'h00A0_0513, 1, 32'h00A0_0513, NOP);

        // retire coincident with second handshake keeps one outstanding
        base = hs_log.size(); d0 = done_cnt;
        bus.inst_ready = 1'b1;
        send_cmd(2'd1, 5'd6, 32'h1234_5678);
        cyc(1);
        bus.inst_retire = 1'b1;
        cyc(1);
        bus.inst_retire = 1'b0;
        chk("coinc_hs", hs_log.size(), base + 2);
        cyc(3);
        chk("coinc_busy", {31'd0, bus.busy}, 32'd1);
        chk("coinc_nodone", done_cnt, d0);
        pulse_retire();
        wait_done("coinc_done", d0);
        chk("coinc_err", {31'd0, last_err}, 32'd0);
        check_words("coinc", base, 2, 32'h1234_5337, 32'h6783_0313);

        // retire timeout: done+error TIMEOUT cycles after entering the wait
        base = hs_log.size(); d0 = done_cnt;
        send_cmd(2'd0, 5'd0, 32'h0010_0093);
        wait_hs("tmo_hs", base + 1);
        wait_done("tmo_done", d0);
        chk("tmo_err", {31'd0, last_err}, 32'd1);
        chk("tmo_latency", done_neg - last_hs_neg, TMO + 1);

        // illegal op, then a command accepted in the done cycle
        base = hs_log.size(); d0 = done_cnt; v0 = valid_cnt;
        send_cmd(2'd3, 5'd4, 32'h1111_2222);
        send_cmd(2'd0, 5'd0, 32'h0020_0113);
        chk("ill_done", done_cnt, d0 + 1);
        chk("ill_err", {31'd0, last_err}, 32'd1);
        chk("ill_novalid", valid_cnt, v0);
        wait_hs("b2b_hs", base + 1);
        pulse_retire();
        wait_done("b2b_done", d0 + 1);
        chk("b2b_err", {31'd0, last_err}, 32'd0);
        check_words("b2b", base, 1, 32'h0020_0113, NOP);

        // reset during ISSUE aborts immediately without a done pulse
        d0 = done_cnt;
        bus.inst_ready = 1'b0;
        send_cmd(2'd1, 5'd5, 32'h1234_5FFF);
        cyc(2);
        chk("pre_rst_valid", {31'd0, bus.inst_valid}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_inst", bus.inst, NOP);
        cyc(2);
        nrst = 1'b1;
        cyc(1);
        chk("mid_rst_nodone", done_cnt, d0);
        run_simple("post_rst", 2'd1, 5'd1, 32'h0000_0123, 1, 32'h1230_0093, NOP);

        cyc(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
